uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and frame scheduler that shares one uart_transmit instance among NUM_REQ byte producers.
- Sits between the producers and uart_transmit's dataReady/dataIn inputs.
- uart_transmit has no busy output, so this block times each frame itself. It issues a new launch only after the previous frame, plus a configurable guard gap, has finished.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter and frame scheduler that shares one
// uart_transmit among NUM_REQ byte producers. uart_transmit has no busy
// output, so each launched frame (10 bits plus GAP_BITS idle bits) is timed
// here before the next launch is allowed.
//
// Optional build macro UART_ARB_LOCK_EN adds the req_lock input: the current
// owner keeps top priority while its lock bit is set, so a multi-byte
// message goes out back-to-back without interleaving.
//
// Handshake: req_valid[i] is raised with req_data[8i+7:8i] stable and held
// until req_ack[i] pulses for one cycle; that pulse coincides with the
// tx_data_ready launch strobe, and at most one ack bit is ever high.
module uart_tx_arbiter #(
    parameter int CLK_HZ   = 5_000_000,
    parameter int BAUD     = 9600,
    parameter int NUM_REQ  = 4,
    parameter int GAP_BITS = 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       tx_data_ready,
    output logic [7:0]                 tx_data_in,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_owner,
    output logic [1:0]                 dbg_state
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int FRAME_CLKS   = (10 + GAP_BITS) * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(FRAME_CLKS);
    localparam int OWN_W        = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t             state;
    logic [OWN_W-1:0]   ptr;
    logic [CNT_W-1:0]   count;

    logic               grant_found;
    logic [OWN_W-1:0]   grant_idx;
    logic [OWN_W:0]     cand;
    logic [OWN_W-1:0]   next_ptr;

    assign dbg_state = state;

    // Pick the first valid requester scanning upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (OWN_W+1)'(k);
            if (cand >= (OWN_W+1)'(NUM_REQ)) begin
                cand = cand - (OWN_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[OWN_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[OWN_W-1:0];
            end
        end
    end

    // Priority pointer for the next scan: rotate past the owner unless it holds the lock.
    always_comb begin
        if (cur_owner == OWN_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = cur_owner + OWN_W'(1);
        end
`ifdef UART_ARB_LOCK_EN
        if (req_lock[cur_owner]) begin
            next_ptr = cur_owner;
        end
`endif
    end

    // Scheduler FSM: grant in IDLE, strobe for one LAUNCH cycle, then time the frame in WAIT.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= '0;
            count         <= '0;
            req_ack       <= '0;
            tx_data_ready <= 1'b0;
            tx_data_in    <= 8'h00;
            busy          <= 1'b0;
            cur_owner     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ack       <= '0;
                    tx_data_ready <= 1'b0;
                    if (grant_found) begin
                        tx_data_in    <= req_data[8*grant_idx +: 8];
                        cur_owner     <= grant_idx;
                        req_ack       <= NUM_REQ'(1) << grant_idx;
                        tx_data_ready <= 1'b1;
                        busy          <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Load FRAME_CLKS-2 so WAIT lasts FRAME_CLKS-1 cycles and busy
                    // spans exactly FRAME_CLKS cycles including this one.
                    req_ack       <= '0;
                    tx_data_ready <= 1'b0;
                    count         <= CNT_W'(FRAME_CLKS - 2);
                    state         <= WAIT;
                end
                WAIT: begin
                    if (count == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with CLK_HZ=100, BAUD=10, NUM_REQ=4, GAP_BITS=1
// (FRAME_CLKS=110). The reference model is a launch timeline: the arbiter is
// free from FRAME_CLKS cycles after the last launch, and a free cycle with any
// valid request launches on the next cycle to the rotation winner.
module tb_uart_tx_arbiter;

    localparam int CLK_HZ     = 100;
    localparam int BAUD       = 10;
    localparam int NUM_REQ    = 4;
    localparam int GAP_BITS   = 1;
    localparam int FRAME_CLKS = (10 + GAP_BITS) * (CLK_HZ / BAUD);

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h0;
`ifdef UART_ARB_LOCK_EN
    logic [3:0]  req_lock = 4'b0000;
`endif
    logic [3:0]  req_ack;
    logic        tx_data_ready;
    logic [7:0]  tx_data_in;
    logic        busy;
    logic [1:0]  cur_owner;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         cyc = 0;
    int         m_launch = -1000000;
    int         m_ptr = 0;
    int         m_owner = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] exp_q[$];

    uart_tx_arbiter #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .NUM_REQ  (NUM_REQ),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
`ifdef UART_ARB_LOCK_EN
        .req_lock      (req_lock),
`endif
        .req_ack       (req_ack),
        .tx_data_ready (tx_data_ready),
        .tx_data_in    (tx_data_in),
        .busy          (busy),
        .cur_owner     (cur_owner),
        .dbg_state     (dbg_state)
    );

    // Clock
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Advance one clock, update the model with the inputs seen at that edge,
    // then return at the falling edge where outputs are sampled and inputs driven.
    task automatic run_cycle();
        int w;
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            m_launch = -1000000;
            m_ptr    = 0;
            m_owner  = 0;
            m_data   = 8'h00;
        end else if (cyc - 1 == m_launch + FRAME_CLKS - 1) begin
            m_ptr = (m_owner + 1) % NUM_REQ;
`ifdef UART_ARB_LOCK_EN
            if (req_lock[m_owner]) m_ptr = m_owner;
`endif
        end else if (cyc - 1 >= m_launch + FRAME_CLKS && req_valid != 4'b0000) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
            end
            m_launch = cyc;
            m_owner  = w;
            m_data   = req_data[8*w +: 8];
            exp_q.push_back(m_data);
        end
        @(negedge clock);
    endtask

    task automatic apply_reset(input int n);
        reset_n   = 1'b0;
        req_valid = 4'b0000;
`ifdef UART_ARB_LOCK_EN
        req_lock  = 4'b0000;
`endif
        repeat (n) run_cycle();
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d0;
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
        d0 = req_data[7:0];
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            checks++;
            if ({req_ack, tx_data_ready, tx_data_in, busy, cur_owner} !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d got ack=%b rdy=%b data=%h busy=%b owner=%0d, expected all 0",
                         i, req_ack, tx_data_ready, tx_data_in, busy, cur_owner);
            end
        end
        reset_n = 1'b1;
        run_cycle();
        checks++;
        if (req_ack !== 4'b0001 || tx_data_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got ack=%b rdy=%b, expected ack=0001 rdy=1", req_ack, tx_data_ready);
        end
        checks++;
        if (tx_data_in !== d0 || cur_owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_data: got data=%h owner=%0d, expected data=%h owner=0", tx_data_in, cur_owner, d0);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        int stray;
        int bad_data;
        apply_reset(2);
        req_data[7:0] = 8'h55;
        req_valid     = 4'b0001;
        run_cycle();
        checks++;
        if (req_ack !== 4'b0001 || tx_data_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_launch: got ack=%b rdy=%b busy=%b, expected ack=0001 rdy=1 busy=1", req_ack, tx_data_ready, busy);
        end
        checks++;
        if (tx_data_in !== 8'h55) begin
            errors++;
            $display("FAIL single_data: got %h, expected 55", tx_data_in);
        end
        req_valid = 4'b0000;
        stray     = 0;
        bad_data  = 0;
        for (int j = 2; j <= FRAME_CLKS + 2; j++) begin
            run_cycle();
            if (tx_data_ready !== 1'b0 || req_ack !== 4'b0000) stray++;
            if (tx_data_in !== 8'h55) bad_data++;
            checks++;
            if (busy !== (j <= FRAME_CLKS)) begin
                errors++;
                $display("FAIL single_busy: offset %0d got busy=%b, expected %b", j, busy, (j <= FRAME_CLKS));
            end
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL single_strobes: got %0d stray strobe cycles, expected 0", stray);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL single_data_hold: got %0d cycles without 55 on tx_data_in, expected 0", bad_data);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int lc[5];
        int own[5];
        logic [7:0] dat[5];
        apply_reset(2);
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'b1111;
        n = 0;
        for (int c = 0; c < 6 * FRAME_CLKS && n < 5; c++) begin
            run_cycle();
            if (tx_data_ready) begin
                lc[n]  = cyc;
                own[n] = -1;
                for (int b = 0; b < 4; b++) if (req_ack[b]) own[n] = b;
                if ($countones(req_ack) != 1) own[n] = -2;
                dat[n] = tx_data_in;
                n++;
            end
        end
        req_valid = 4'b0000;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d launches, expected 5", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (own[i] != i % 4 || dat[i] !== 8'(8'hA0 + i % 4)) begin
                errors++;
                $display("FAIL rr_grant: launch %0d got owner=%0d data=%h, expected owner=%0d data=%h",
                         i, own[i], dat[i], i % 4, 8'(8'hA0 + i % 4));
            end
            if (i > 0) begin
                checks++;
                if (lc[i] - lc[i-1] != FRAME_CLKS + 1) begin
                    errors++;
                    $display("FAIL rr_spacing: launch %0d got spacing %0d, expected %0d", i, lc[i] - lc[i-1], FRAME_CLKS + 1);
                end
            end
        end
    endtask

    task automatic test_drop_before_grant();
        int l;
        int ack2;
        int extra;
        apply_reset(2);
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
        req_valid = 4'b0001;
        run_cycle();
        l = cyc;
        checks++;
        if (tx_data_ready !== 1'b1 || req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL drop_launch: got rdy=%b ack=%b, expected rdy=1 ack=0001", tx_data_ready, req_ack);
        end
        req_valid = 4'b0000;
        ack2  = 0;
        extra = 0;
        for (int j = 1; j <= FRAME_CLKS + 5; j++) begin
            if (j == 20) req_valid[2] = 1'b1;
            if (j == 60) req_valid[2] = 1'b0;
            run_cycle();
            if (req_ack[2]) ack2++;
            if (tx_data_ready) extra++;
            checks++;
            if (busy !== (cyc - l < FRAME_CLKS)) begin
                errors++;
                $display("FAIL drop_busy: offset %0d got busy=%b, expected %b", j, busy, (cyc - l < FRAME_CLKS));
            end
        end
        checks++;
        if (ack2 != 0 || extra != 0) begin
            errors++;
            $display("FAIL drop_no_grant: got %0d acks to req 2 and %0d extra launches, expected 0 and 0", ack2, extra);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d0;
        apply_reset(2);
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
        d0 = req_data[7:0];
        req_valid = 4'b0001;
        run_cycle();
        req_valid = 4'b0000;
        for (int j = 0; j < FRAME_CLKS + 5 && busy; j++) run_cycle();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_frame_end: got busy=%b, expected 0", busy);
        end
        req_valid = 4'b0010;
        run_cycle();
        checks++;
        if (req_ack !== 4'b0010) begin
            errors++;
            $display("FAIL mid_second_grant: got ack=%b, expected 0010", req_ack);
        end
        req_valid = 4'b0000;
        repeat (50) run_cycle();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_busy: got busy=%b, expected 1", busy);
        end
        reset_n = 1'b0;
        run_cycle();
        checks++;
        if ({req_ack, tx_data_ready, tx_data_in, busy, cur_owner} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ack=%b rdy=%b data=%h busy=%b owner=%0d, expected all 0",
                     req_ack, tx_data_ready, tx_data_in, busy, cur_owner);
        end
        reset_n   = 1'b1;
        req_valid = 4'b0011;
        run_cycle();
        checks++;
        if (req_ack !== 4'b0001 || tx_data_in !== d0) begin
            errors++;
            $display("FAIL mid_restart_grant: got ack=%b data=%h, expected ack=0001 data=%h", req_ack, tx_data_in, d0);
        end
        req_valid = 4'b0000;
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        int n;
        int own[5];
        int expect_own[5];
        expect_own = '{1, 1, 1, 1, 3};
        apply_reset(2);
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
        req_valid = 4'b1010;
        req_lock  = 4'b0010;
        n = 0;
        for (int c = 0; c < 6 * FRAME_CLKS && n < 5; c++) begin
            run_cycle();
            if (tx_data_ready) begin
                own[n] = -1;
                for (int b = 0; b < 4; b++) if (req_ack[b]) own[n] = b;
                n++;
                if (n == 4) req_lock = 4'b0000;
            end
        end
        req_valid = 4'b0000;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL lock_count: got %0d launches, expected 5", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (own[i] != expect_own[i]) begin
                errors++;
                $display("FAIL lock_grant: launch %0d got owner=%0d, expected %0d", i, own[i], expect_own[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] e;
        apply_reset(2);
        for (int c = 0; c < 4000; c++) begin
            reset_n = ($urandom_range(0, 999) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 3) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom_range(0, 255));
                end
            end
`ifdef UART_ARB_LOCK_EN
            if ($urandom_range(0, 49) == 0) req_lock = 4'($urandom_range(0, 15));
`endif
            run_cycle();
            checks++;
            if (tx_data_ready !== (cyc == m_launch)) begin
                errors++;
                $display("FAIL rand_ready: cycle %0d got %b, expected %b", cyc, tx_data_ready, (cyc == m_launch));
            end
            checks++;
            if (req_ack !== ((cyc == m_launch) ? 4'(1 << m_owner) : 4'b0000)) begin
                errors++;
                $display("FAIL rand_ack: cycle %0d got %b, expected %b", cyc, req_ack,
                         ((cyc == m_launch) ? 4'(1 << m_owner) : 4'b0000));
            end
            checks++;
            if (busy !== (cyc >= m_launch && cyc < m_launch + FRAME_CLKS)) begin
                errors++;
                $display("FAIL rand_busy: cycle %0d got %b, expected %b", cyc, busy,
                         (cyc >= m_launch && cyc < m_launch + FRAME_CLKS));
            end
            checks++;
            if (tx_data_in !== m_data || cur_owner !== 2'(m_owner)) begin
                errors++;
                $display("FAIL rand_data_owner: cycle %0d got data=%h owner=%0d, expected data=%h owner=%0d",
                         cyc, tx_data_in, cur_owner, m_data, m_owner);
            end
            if (tx_data_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_scoreboard: launch of %h with no expected byte queued", tx_data_in);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data_in !== e) begin
                        errors++;
                        $display("FAIL rand_scoreboard: got %h, expected %h", tx_data_in, e);
                    end
                end
            end
            for (int i = 0; i < 4; i++) if (req_ack[i] === 1'b1) req_valid[i] = 1'b0;
        end
        reset_n = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_leftover: got %0d expected bytes never launched, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop_before_grant();
        test_reset_mid();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
